// File: rtl/zap_pkg.sv
// Shared definitions for the ZAP Wishbone fabric: bus widths, master
// indices, arbiter state encoding and the request bundle one master drives.
package zap_pkg;

   localparam int unsigned WB_AW = 32;
   localparam int unsigned WB_DW = 32;
   localparam int unsigned WB_SW = 4;

   // Master indices: 0 is the TLB page-walk FSM, 1 the cache line-fill FSM.
   localparam logic MST_0 = 1'b0;
   localparam logic MST_1 = 1'b1;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2
   } arb_state_e;

   // Everything a master presents to the slave side, in port order.
   typedef struct packed {
      logic             cyc;
      logic             stb;
      logic             wen;
      logic [WB_SW-1:0] sel;
      logic [WB_AW-1:0] adr;
      logic [WB_DW-1:0] dat;
   } wb_req_t;

   localparam wb_req_t WB_REQ_IDLE = '0;

   // One-hot grant vector for an arbiter state.
   function automatic logic [1:0] gnt_onehot(arb_state_e st);
      logic [1:0] g;
      case (st)
         ARB_GNT0: g = GNT_M0;
         ARB_GNT1: g = GNT_M1;
         default:  g = GNT_NONE;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/zap_wb_watchdog.sv
// Stall watchdog: counts consecutive cycles of an un-acknowledged strobe
// and raises a sticky flag once the count has reached TIMEOUT.
module zap_wb_watchdog #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_arm,
   input  logic i_ack,
   input  logic i_clr,
   output logic o_flag
);

   localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          flag_q, flag_d;
   logic          hit;

   // Next-state for the saturating stall counter and the sticky flag.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      cnt_d  = '0;
      flag_d = flag_q;
      hit    = (cnt_q == CNT_MAX);

      if (i_arm && !i_ack) begin
         cnt_d = hit ? cnt_q : cnt_q + 1'b1;
      end

      // Set is evaluated after clear so a coincident set wins.
      if (i_clr) begin
         flag_d = 1'b0;
      end
      if (hit) begin
         flag_d = 1'b1;
      end
   end

   // Counter and flag registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!i_reset_n) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign o_flag = flag_q;

endmodule

// File: rtl/zap_tlb_wb_arb.sv
// Two-master Wishbone arbiter between the TLB page-walk FSM (master 0) and
// the cache line-fill FSM (master 1). A grant is held for the whole cyc
// window; every handover passes through IDLE, and ties go to the master
// that was not served last. A watchdog flags slave stalls.
module zap_tlb_wb_arb
   import zap_pkg::*;
#(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic             i_clk,
   input  logic             i_reset_n,

   input  logic             i_m0_cyc,
   input  logic             i_m0_stb,
   input  logic             i_m0_wen,
   input  logic [WB_SW-1:0] i_m0_sel,
   input  logic [WB_AW-1:0] i_m0_adr,
   input  logic [WB_DW-1:0] i_m0_dat,

   input  logic             i_m1_cyc,
   input  logic             i_m1_stb,
   input  logic             i_m1_wen,
   input  logic [WB_SW-1:0] i_m1_sel,
   input  logic [WB_AW-1:0] i_m1_adr,
   input  logic [WB_DW-1:0] i_m1_dat,

   output logic             o_m0_ack,
   output logic             o_m1_ack,
   output logic [WB_DW-1:0] o_mx_dat,

   output logic             o_wb_cyc,
   output logic             o_wb_stb,
   output logic             o_wb_wen,
   output logic [WB_SW-1:0] o_wb_sel,
   output logic [WB_AW-1:0] o_wb_adr,
   output logic [WB_DW-1:0] o_wb_dat,
   input  logic             i_wb_ack,
   input  logic [WB_DW-1:0] i_wb_dat,

   output logic [1:0]       o_gnt,
   output logic             o_timeout,
   input  logic             i_timeout_clr
);

   wb_req_t    m0_req;
   wb_req_t    m1_req;
   wb_req_t    wb_req;
   arb_state_e state_q;
   logic       last_gnt_q;
   logic [1:0] gnt_q;
   logic       wd_arm;

   assign m0_req = {i_m0_cyc, i_m0_stb, i_m0_wen, i_m0_sel, i_m0_adr, i_m0_dat};
   assign m1_req = {i_m1_cyc, i_m1_stb, i_m1_wen, i_m1_sel, i_m1_adr, i_m1_dat};

   // Grant FSM: picks an owner from IDLE and holds it until its cyc drops.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ARB_IDLE;
         last_gnt_q <= MST_1;
         gnt_q      <= GNT_NONE;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (i_m0_cyc && (!i_m1_cyc || last_gnt_q == MST_1)) begin
                  state_q <= ARB_GNT0;
                  gnt_q   <= gnt_onehot(ARB_GNT0);
               end else if (i_m1_cyc) begin
                  state_q <= ARB_GNT1;
                  gnt_q   <= gnt_onehot(ARB_GNT1);
               end
            end
            ARB_GNT0: begin
               if (!i_m0_cyc) begin
                  state_q    <= ARB_IDLE;
                  last_gnt_q <= MST_0;
                  gnt_q      <= gnt_onehot(ARB_IDLE);
               end
            end
            ARB_GNT1: begin
               if (!i_m1_cyc) begin
                  state_q    <= ARB_IDLE;
                  last_gnt_q <= MST_1;
                  gnt_q      <= gnt_onehot(ARB_IDLE);
               end
            end
            default: begin
               state_q <= ARB_IDLE;
               gnt_q   <= GNT_NONE;
            end
         endcase
      end
   end

   // Slave-side mux and ack steering: a pure copy of the owner's signals,
   // so a dropped cyc reaches the slave in the same cycle.
   always_comb begin
      wb_req   = WB_REQ_IDLE;
      o_m0_ack = 1'b0;
      o_m1_ack = 1'b0;
      case (state_q)
         ARB_GNT0: begin
            wb_req   = m0_req;
            o_m0_ack = i_wb_ack;
         end
         ARB_GNT1: begin
            wb_req   = m1_req;
            o_m1_ack = i_wb_ack;
         end
         default: ;
      endcase
   end

   assign o_wb_cyc = wb_req.cyc;
   assign o_wb_stb = wb_req.stb;
   assign o_wb_wen = wb_req.wen;
   assign o_wb_sel = wb_req.sel;
   assign o_wb_adr = wb_req.adr;
   assign o_wb_dat = wb_req.dat;
   assign o_mx_dat = i_wb_dat;
   assign o_gnt    = gnt_q;

   // The watchdog only observes; it never feeds back into grant or acks.
   assign wd_arm = (state_q != ARB_IDLE) && wb_req.stb;

   zap_wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_arm     (wd_arm),
      .i_ack     (i_wb_ack),
      .i_clr     (i_timeout_clr),
      .o_flag    (o_timeout)
   );

endmodule
